// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CNN layer accelerator input streamer.
package cnn_layer_accel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_NEWMAP,
    ST_GAP0,
    ST_SEQ,
    ST_GAP1,
    ST_PIX
  } streamer_state_e;

  localparam int SEQ_RM_BIT    = 12;
  localparam int SEQ_RST_BIT   = 11;
  localparam int SEQ_P_BIT     = 10;
  localparam int SEQ_W         = 10;
  localparam int WORDS_PER_GRP = 5;

endpackage

// File: rtl/cnn_layer_accel_seq_gen.sv
// Combinational sequence-word generator: (group, word-in-group) -> tagged sequence word.
module cnn_layer_accel_seq_gen
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_SEQ_DATA_WIDTH = 13,
  parameter int C_DIM_WIDTH      = 10
) (
  input  logic [C_DIM_WIDTH-1:0]      grp_i,
  input  logic [2:0]                  wrd_i,
  output logic [C_SEQ_DATA_WIDTH-1:0] word_o
);

  logic [SEQ_W-1:0] g10;

  always_comb begin
    word_o = '0;
    g10    = SEQ_W'(grp_i);
    case (wrd_i)
      3'd0: begin
        word_o[SEQ_RST_BIT]   = 1'b1;
        word_o[SEQ_P_BIT]     = ~g10[0];
        word_o[SEQ_W-1:0]     = g10;
      end
      3'd1: begin
        word_o[SEQ_P_BIT]     = g10[0];
        word_o[SEQ_W-1:0]     = SEQ_W'(2) + (g10 & ~SEQ_W'(1));
      end
      3'd2: word_o[SEQ_W-1:0] = SEQ_W'(512) + g10;
      3'd3: word_o[SEQ_W-1:0] = SEQ_W'(513) + g10;
      3'd4: begin
        word_o[SEQ_RM_BIT]    = 1'b1;
        word_o[SEQ_W-1:0]     = SEQ_W'(514) + g10;
      end
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/cnn_layer_accel_input_streamer.sv
// Streams new_map, the generated sequence table and then the map's pixels into the octo.
// Optional stall counter output enabled by defining CNN_ACCEL_STREAMER_STALL_CNT_EN.
module cnn_layer_accel_input_streamer
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_SEQ_DATA_WIDTH = 13,
  parameter int C_DIM_WIDTH      = 10,
  parameter int C_KERNEL_SIZE    = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [C_DIM_WIDTH-1:0]   num_input_rows_cfg,
  input  logic [C_DIM_WIDTH-1:0]   num_input_cols_cfg,
  input  logic [C_PIXEL_WIDTH-1:0] pix_in,
  input  logic                     pix_in_valid,
  output logic                     pix_in_rdy,
  output logic                     new_map,
  output logic [C_PIXEL_WIDTH-1:0] datain,
  output logic                     datain_valid,
  output logic                     seq_datain_tag,
  input  logic                     seq_datain_rdy,
  output logic                     pixel_datain_tag,
  input  logic                     pixel_datain_rdy,
  output logic                     busy,
  output logic                     done,
`ifdef CNN_ACCEL_STREAMER_STALL_CNT_EN
  output logic [31:0]              stall_count,
`endif
  output logic                     cfg_err
);

  localparam int IDX_W = $clog2(WORDS_PER_GRP * (2 ** C_DIM_WIDTH));
  localparam int PIX_W = 2 * C_DIM_WIDTH;

  streamer_state_e             state_q;
  logic [C_DIM_WIDTH-1:0]      grp_q, grp_d;
  logic [2:0]                  wrd_q, wrd_d;
  logic [IDX_W-1:0]            idx_q, seq_last_q;
  logic [PIX_W-1:0]            acc_q, sent_q, pix_last_q;
  logic                        acc_all_q;
  logic [C_PIXEL_WIDTH-1:0]    datain_q;
  logic                        valid_q, seq_tag_q, pix_tag_q;
  logic                        new_map_q, done_q, cfg_err_q;
  logic [C_SEQ_DATA_WIDTH-1:0] seq_word;
  logic                        cols_ok, start_ok, seq_xfer, pix_xfer, pix_acc;

  assign cols_ok  = (int'(num_input_cols_cfg) + 1) >= C_KERNEL_SIZE;
  assign start_ok = (state_q == ST_IDLE) && start && cols_ok;
  assign seq_xfer = valid_q && seq_tag_q && seq_datain_rdy;
  assign pix_xfer = valid_q && pix_tag_q && pixel_datain_rdy;

  assign pix_in_rdy = (state_q == ST_PIX) && !acc_all_q && (!valid_q || pixel_datain_rdy);
  assign pix_acc    = pix_in_rdy && pix_in_valid;

  // The word loaded into the output register is the one after the current index
  always_comb begin
    grp_d = grp_q;
    wrd_d = wrd_q + 3'd1;
    if (state_q == ST_GAP0) begin
      grp_d = '0;
      wrd_d = '0;
    end else if (wrd_q == 3'(WORDS_PER_GRP - 1)) begin
      grp_d = grp_q + C_DIM_WIDTH'(1);
      wrd_d = '0;
    end
  end

  cnn_layer_accel_seq_gen #(
    .C_SEQ_DATA_WIDTH (C_SEQ_DATA_WIDTH),
    .C_DIM_WIDTH      (C_DIM_WIDTH)
  ) u_seq_gen (
    .grp_i  (grp_d),
    .wrd_i  (wrd_d),
    .word_o (seq_word)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      grp_q      <= '0;
      wrd_q      <= '0;
      idx_q      <= '0;
      seq_last_q <= '0;
      acc_q      <= '0;
      sent_q     <= '0;
      pix_last_q <= '0;
      acc_all_q  <= 1'b0;
      datain_q   <= '0;
      valid_q    <= 1'b0;
      seq_tag_q  <= 1'b0;
      pix_tag_q  <= 1'b0;
      new_map_q  <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      new_map_q <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && cols_ok) begin
            seq_last_q <= IDX_W'(WORDS_PER_GRP * (int'(num_input_cols_cfg) + 2 - C_KERNEL_SIZE) - 1);
            pix_last_q <= PIX_W'(num_input_rows_cfg) * PIX_W'(num_input_cols_cfg)
                        + PIX_W'(num_input_rows_cfg) + PIX_W'(num_input_cols_cfg);
            new_map_q  <= 1'b1;
            state_q    <= ST_NEWMAP;
          end else if (start) begin
            cfg_err_q  <= 1'b1;
          end
        end
        ST_NEWMAP: state_q <= ST_GAP0;
        ST_GAP0: begin
          grp_q     <= grp_d;
          wrd_q     <= wrd_d;
          idx_q     <= '0;
          datain_q  <= C_PIXEL_WIDTH'(seq_word);
          valid_q   <= 1'b1;
          seq_tag_q <= 1'b1;
          state_q   <= ST_SEQ;
        end
        ST_SEQ: begin
          if (seq_xfer) begin
            if (idx_q == seq_last_q) begin
              valid_q   <= 1'b0;
              seq_tag_q <= 1'b0;
              state_q   <= ST_GAP1;
            end else begin
              grp_q    <= grp_d;
              wrd_q    <= wrd_d;
              idx_q    <= idx_q + IDX_W'(1);
              datain_q <= C_PIXEL_WIDTH'(seq_word);
            end
          end
        end
        ST_GAP1: begin
          acc_q     <= '0;
          sent_q    <= '0;
          acc_all_q <= 1'b0;
          state_q   <= ST_PIX;
        end
        ST_PIX: begin
          if (pix_xfer) begin
            sent_q <= sent_q + PIX_W'(1);
            if (sent_q == pix_last_q) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
          // A fresh accept refills the output register in the same cycle it drains
          if (pix_acc) begin
            datain_q  <= pix_in;
            valid_q   <= 1'b1;
            pix_tag_q <= 1'b1;
            acc_q     <= acc_q + PIX_W'(1);
            if (acc_q == pix_last_q) acc_all_q <= 1'b1;
          end else if (pix_xfer) begin
            valid_q   <= 1'b0;
            pix_tag_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef CNN_ACCEL_STREAMER_STALL_CNT_EN
  logic [31:0] stall_q;
  always_ff @(posedge clk) begin
    if (!rst || start_ok) begin
      stall_q <= '0;
    end else if (valid_q && ((seq_tag_q && !seq_datain_rdy) || (pix_tag_q && !pixel_datain_rdy))
                 && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
  assign stall_count = stall_q;
`endif

  assign datain           = datain_q;
  assign datain_valid     = valid_q;
  assign seq_datain_tag   = seq_tag_q;
  assign pixel_datain_tag = pix_tag_q;
  assign new_map          = new_map_q;
  assign done             = done_q;
  assign cfg_err          = cfg_err_q;
  assign busy             = (state_q != ST_IDLE);

endmodule
